// File: rtl/matrix_loader.sv
// Stream-to-buffer loader feeding the determinant engine: fills an N x N signed matrix,
// pulses Start, waits for Det_done, pulses Ack. Define MATRIX_LOADER_COLMAJOR_EN for column-major fill.
module matrix_loader #(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic             In_valid,
    input  logic [W-1:0]     In_data,
    output logic             In_ready,
    input  logic             Det_done,
    output logic             Start,
    output logic             Ack,
    output logic [N*N*W-1:0] Mat_flat,
    output logic [6:0]       Elem_cnt,
    output logic             q_I,
    output logic             q_Fill,
    output logic             q_Start,
    output logic             q_Wait,
    output logic             q_Ack
);

    localparam logic [6:0] LAST_IDX = 7'(N*N-1);

    typedef enum logic [4:0] {
        S_I     = 5'b00001,
        S_FILL  = 5'b00010,
        S_START = 5'b00100,
        S_WAIT  = 5'b01000,
        S_ACK   = 5'b10000
    } state_t;

    state_t state;
    int     wr_pos;

    // Handshake: an element transfers on a rising Clk edge where In_valid && In_ready.
    always_comb begin
        wr_pos = 0;
`ifdef MATRIX_LOADER_COLMAJOR_EN
        wr_pos = (int'(Elem_cnt) % N) * N + int'(Elem_cnt) / N;
`else
        wr_pos = int'(Elem_cnt);
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_I;
            Mat_flat <= '0;
            Elem_cnt <= '0;
        end else begin
            case (state)
                S_I: begin
                    if (Load) begin
                        Elem_cnt <= '0;
                        Mat_flat <= '0;
                        state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (In_valid) begin
                        Mat_flat[wr_pos*W +: W] <= In_data;
                        Elem_cnt                <= Elem_cnt + 7'd1;
                        if (Elem_cnt == LAST_IDX) state <= S_START;
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT:  if (Det_done) state <= S_ACK;
                S_ACK:   state <= S_I;
                default: state <= S_I;
            endcase
        end
    end

    // Every output below is a pure decode of the state register.
    assign q_I      = (state == S_I);
    assign q_Fill   = (state == S_FILL);
    assign q_Start  = (state == S_START);
    assign q_Wait   = (state == S_WAIT);
    assign q_Ack    = (state == S_ACK);
    assign In_ready = q_Fill;
    assign Start    = q_Start;
    assign Ack      = q_Ack;

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: scoreboarded fills, element tables and
// hand-written sequences for reset, WAIT and early Det_done cases.
module tb_matrix_loader;

    localparam int N = 8;
    localparam int W = 32;

    logic             Clk = 1'b0;
    logic             Reset, Load, In_valid, Det_done;
    logic [W-1:0]     In_data;
    logic             In_ready, Start, Ack;
    logic [N*N*W-1:0] Mat_flat;
    logic [6:0]       Elem_cnt;
    logic             q_I, q_Fill, q_Start, q_Wait, q_Ack;

    matrix_loader #(.N(N), .W(W)) dut (
        .Clk(Clk), .Reset(Reset), .Load(Load), .In_valid(In_valid), .In_data(In_data),
        .In_ready(In_ready), .Det_done(Det_done), .Start(Start), .Ack(Ack),
        .Mat_flat(Mat_flat), .Elem_cnt(Elem_cnt),
        .q_I(q_I), .q_Fill(q_Fill), .q_Start(q_Start), .q_Wait(q_Wait), .q_Ack(q_Ack)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        int          r;
        int          c;
        logic [31:0] exp;
    } elem_vec_t;

    int          vectors    = 0;
    int          miscompares = 0;
    int          start_cnt  = 0;
    int          ack_cnt    = 0;
    logic [W-1:0] vals[64];
    logic [W-1:0] exp_q[$];

    always @(negedge Clk) begin
        if (Start) start_cnt++;
        if (Ack)   ack_cnt++;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [W-1:0] elem(input int r, input int c);
        return Mat_flat[(r*N+c)*W +: W];
    endfunction

    function automatic int pos_of(input int k);
`ifdef MATRIX_LOADER_COLMAJOR_EN
        return (k % N) * N + k / N;
`else
        return k;
`endif
    endfunction

    // Loads n_elem values from vals[] with In_valid duty cycle in percent.
    // Returns in the cycle right after the last accept (the Start cycle for a full matrix).
    task automatic fill_matrix(input int n_elem, input int duty);
        int  k   = 0;
        int  cyc = 0;
        logic acc;
        check("idle_in_ready_low", {31'd0, In_ready}, 32'd0);
        Load = 1'b1;
        tick();
        Load = 1'b0;
        while (k < n_elem && cyc < 2000) begin
            In_valid = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
            In_data  = vals[k];
            acc      = In_valid && In_ready;
            if (acc) exp_q.push_back(vals[k]);
            tick();
            if (acc) k++;
            cyc++;
        end
        In_valid = 1'b0;
        In_data  = '0;
        if (cyc >= 2000) check("fill_timeout", k, n_elem);
        if (n_elem == N*N) begin
            check("start_after_last", {31'd0, Start}, 32'd1);
            check("elem_cnt_full", {25'd0, Elem_cnt}, 32'd64);
            for (int i = 0; i < N*N && exp_q.size() > 0; i++) begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check($sformatf("sb_elem_k%0d", i), Mat_flat[pos_of(i)*W +: W], e);
            end
        end
    endtask

    task automatic finish_handshake();
        int base = ack_cnt;
        Det_done = 1'b1;
        tick();
        check("ack_high", {31'd0, Ack}, 32'd1);
        Det_done = 1'b0;
        tick();
        check("ack_low_after", {31'd0, Ack}, 32'd0);
        check("back_in_i", {31'd0, q_I}, 32'd1);
        tick();
        check("ack_single_pulse", ack_cnt - base, 32'd1);
    endtask

    elem_vec_t t_ident[3];
    elem_vec_t t_ramp[3];

    initial begin
        int  sbase;
        logic wait_ok;

        t_ident[0] = '{"ident_3_3", 3, 3, 32'd1};
        t_ident[1] = '{"ident_3_4", 3, 4, 32'd0};
        t_ident[2] = '{"ident_0_0", 0, 0, 32'd1};
        t_ramp[0]  = '{"ramp_7_7", 7, 7, 32'd31};
        t_ramp[1]  = '{"ramp_0_0", 0, 0, 32'hFFFF_FFE0};
        t_ramp[2]  = '{"ramp_7_6", 7, 6, 32'd30};

        Reset = 1'b1; Load = 1'b0; In_valid = 1'b0; In_data = '0; Det_done = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        check("rst_q_i", {31'd0, q_I}, 32'd1);
        check("rst_elem_cnt", {25'd0, Elem_cnt}, 32'd0);
        check("rst_mat_zero", {31'd0, (Mat_flat == '0)}, 32'd1);
        check("rst_outs", {29'd0, Start, Ack, In_ready}, 32'd0);

        // Identity matrix, back-to-back.
        for (int k = 0; k < 64; k++) vals[k] = (k / N == k % N) ? 32'd1 : 32'd0;
        sbase = start_cnt;
        fill_matrix(64, 100);
        for (int i = 0; i < 3; i++) check(t_ident[i].name, elem(t_ident[i].r, t_ident[i].c), t_ident[i].exp);
        tick();
        check("wait_after_start", {31'd0, q_Wait}, 32'd1);
        check("start_one_cycle", start_cnt - sbase, 32'd1);
        finish_handshake();

        // Ramp k-32 with ~50% valid duty, then WAIT disturbance.
        for (int k = 0; k < 64; k++) vals[k] = 32'(k - 32);
        fill_matrix(64, 50);
        for (int i = 0; i < 3; i++) check(t_ramp[i].name, elem(t_ramp[i].r, t_ramp[i].c), t_ramp[i].exp);
        tick();
        check("wait_in_ready_low", {31'd0, In_ready}, 32'd0);
        In_valid = 1'b1; In_data = 32'd99; Load = 1'b1;
        tick();
        Load = 1'b0;
        wait_ok = 1'b1;
        for (int i = 0; i < 99; i++) begin
            if (!q_Wait || Ack || In_ready) wait_ok = 1'b0;
            tick();
        end
        In_valid = 1'b0; In_data = '0;
        check("wait_held_100", {31'd0, wait_ok}, 32'd1);
        check("wait_elem_cnt", {25'd0, Elem_cnt}, 32'd64);
        for (int k = 0; k < 64; k++)
            check($sformatf("wait_frozen_k%0d", k), Mat_flat[pos_of(k)*W +: W], vals[k]);
        finish_handshake();
        check("ramp_retained_in_i", elem(7, 7), 32'd31);

        // Reset after 30 accepts.
        for (int k = 0; k < 64; k++) vals[k] = 32'(k + 1);
        sbase = start_cnt;
        fill_matrix(30, 100);
        check("partial_cnt", {25'd0, Elem_cnt}, 32'd30);
        exp_q.delete();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midrst_q_i", {31'd0, q_I}, 32'd1);
        check("midrst_cnt", {25'd0, Elem_cnt}, 32'd0);
        check("midrst_mat_zero", {31'd0, (Mat_flat == '0)}, 32'd1);
        tick(); tick();
        check("midrst_no_start", start_cnt - sbase, 32'd0);

        // Det_done already high when START completes.
        for (int k = 0; k < 64; k++) vals[k] = 32'($urandom());
        fill_matrix(64, 70);
        Det_done = 1'b1;
        tick();
        check("early_done_wait", {31'd0, q_Wait}, 32'd1);
        tick();
        check("early_done_ack", {31'd0, Ack}, 32'd1);
        Det_done = 1'b0;
        tick();
        check("early_done_idle", {31'd0, q_I}, 32'd1);

        // Single non-zero element at k=1 exposes the fill order.
        for (int k = 0; k < 64; k++) vals[k] = (k == 1) ? 32'd5 : 32'd0;
        fill_matrix(64, 100);
`ifdef MATRIX_LOADER_COLMAJOR_EN
        check("order_1_0", elem(1, 0), 32'd5);
        check("order_0_1", elem(0, 1), 32'd0);
`else
        check("order_0_1", elem(0, 1), 32'd5);
        check("order_1_0", elem(1, 0), 32'd0);
`endif
        tick();
        finish_handshake();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
